// File: rtl/data_mem_mmio.sv
// Data-memory responder: word RAM plus a small MMIO window
// with cycle/store counters, scratch register and debug FIFO.
module data_mem_mmio #(
  parameter int unsigned DEPTH      = 1024,
  parameter logic [31:0] MMIO_BASE  = 32'hFFFF_FF00,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemWriteM,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  output logic [31:0] ReadDataM,
  output logic        dbg_valid,
  output logic [31:0] dbg_data,
  input  logic        dbg_ready
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  logic [31:0]   mem_q [DEPTH];
  logic [31:0]   fifo_q [FIFO_DEPTH];
  logic [PW-1:0] rptr_q, rptr_d;
  logic [PW-1:0] wptr_q, wptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ovf_q, ovf_d;
  logic [31:0]   cycle_q;
  logic [31:0]   stores_q;
  logic [31:0]   scr_q;

  logic          mmio;
  logic [AW-1:0] idx;
  logic [5:0]    off;
  logic          ram_we, tx_we, st_we, scr_we;
  logic          full, empty, pop, push;
  logic          ovf_set, ovf_clr;
  logic [31:0]   status;
  logic          unused_lo;

  assign mmio      = ALUResultM[31:8] == MMIO_BASE[31:8];
  assign idx       = ALUResultM[AW+1:2];
  assign off       = ALUResultM[7:2];
  assign unused_lo = ^ALUResultM[1:0];

  assign ram_we = MemWriteM && !mmio;
  assign tx_we  = MemWriteM && mmio && off == 6'h02;
  assign st_we  = MemWriteM && mmio && off == 6'h03;
  assign scr_we = MemWriteM && mmio && off == 6'h04;

  assign full    = cnt_q == CW'(FIFO_DEPTH);
  assign empty   = cnt_q == '0;
  assign pop     = !empty && dbg_ready;
  assign push    = tx_we && (!full || pop);
  assign ovf_set = tx_we && !push;
  assign ovf_clr = st_we && WriteDataM[2];

  assign status = {24'h0, 4'(cnt_q), 1'b0,
                   ovf_q, empty, full};

  assign dbg_valid = !empty;
  assign dbg_data  = fifo_q[rptr_q];

  // FIFO pointer/count and sticky overflow next state
  always_comb begin
    rptr_d = rptr_q;
    wptr_d = wptr_q;
    cnt_d  = cnt_q + CW'(push) - CW'(pop);
    ovf_d  = ovf_set | (ovf_q & ~ovf_clr);
    if (pop)  rptr_d = rptr_q + PW'(1);
    if (push) wptr_d = wptr_q + PW'(1);
  end

  // Load path: combinational RAM or MMIO register read
  always_comb begin
    ReadDataM = '0;
    if (mmio) begin
      if (!rst) begin
        unique case (off)
          6'h00:   ReadDataM = cycle_q;
          6'h01:   ReadDataM = stores_q;
          6'h03:   ReadDataM = status;
          6'h04:   ReadDataM = scr_q;
          default: ReadDataM = '0;
        endcase
      end
    end else begin
      ReadDataM = mem_q[idx];
    end
  end

  // RAM write port, untouched by reset
  always_ff @(posedge clk) begin
    if (ram_we) mem_q[idx] <= WriteDataM;
  end

  // Counters, scratch and FIFO control registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycle_q  <= '0;
      stores_q <= '0;
      scr_q    <= '0;
      rptr_q   <= '0;
      wptr_q   <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      cycle_q <= cycle_q + 32'd1;
      if (ram_we) stores_q <= stores_q + 32'd1;
      if (scr_we) scr_q <= WriteDataM;
      rptr_q <= rptr_d;
      wptr_q <= wptr_d;
      cnt_q  <= cnt_d;
      ovf_q  <= ovf_d;
    end
  end

  // FIFO storage, cleared so the head reads 0 after reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++)
        fifo_q[i] <= '0;
    end else if (push) begin
      fifo_q[wptr_q] <= WriteDataM;
    end
  end

endmodule

// File: tb/tb_data_mem_mmio.sv
// Bench for data_mem_mmio: directed plan steps then random
// traffic against a queue/array reference model.
module tb_data_mem_mmio;

  localparam int DEPTH = 1024;
  localparam int FD    = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        we = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wd = '0;
  logic        rdy = 1'b0;
  logic [31:0] rd;
  logic        dv;
  logic [31:0] dd;

  int checks = 0;
  int errors = 0;

  bit   [31:0] m_mem [DEPTH];
  logic [31:0] m_q [$];
  logic [31:0] m_cycle, m_stores, m_scr;
  bit          m_ovf;

  logic [7:0] offs [8] = '{8'h00, 8'h04, 8'h08, 8'h08,
                           8'h0C, 8'h10, 8'h14, 8'h20};

  data_mem_mmio #(
    .DEPTH(DEPTH),
    .MMIO_BASE(32'hFFFF_FF00),
    .FIFO_DEPTH(FD)
  ) dut (
    .clk(clk),
    .rst(rst),
    .MemWriteM(we),
    .ALUResultM(addr),
    .WriteDataM(wd),
    .ReadDataM(rd),
    .dbg_valid(dv),
    .dbg_data(dd),
    .dbg_ready(rdy)
  );

  always #5 clk = ~clk;

  function automatic bit is_mmio(input logic [31:0] a);
    return a[31:8] == 24'hFFFFFF;
  endfunction

  function automatic logic [31:0] m_status();
    int n = m_q.size();
    return {24'h0, 4'(n), 1'b0, m_ovf, n == 0, n == FD};
  endfunction

  function automatic logic [31:0] m_read(input logic [31:0] a);
    if (is_mmio(a)) begin
      if (rst) return '0;
      case (a[7:0])
        8'h00:   return m_cycle;
        8'h04:   return m_stores;
        8'h0C:   return m_status();
        8'h10:   return m_scr;
        default: return '0;
      endcase
    end
    return m_mem[(a >> 2) % DEPTH];
  endfunction

  task automatic m_reset();
    m_q.delete();
    m_cycle  = '0;
    m_stores = '0;
    m_scr    = '0;
    m_ovf    = 1'b0;
  endtask

  // Reference: apply one clock edge with the current inputs
  task automatic m_edge();
    bit popd, acc, txw, setv, clrv;
    logic [7:0] o;
    o    = addr[7:0];
    popd = (m_q.size() != 0) && rdy;
    txw  = we && is_mmio(addr) && o == 8'h08;
    acc  = (m_q.size() < FD) || popd;
    setv = txw && !acc;
    clrv = we && is_mmio(addr) && o == 8'h0C && wd[2];
    if (we && !is_mmio(addr)) begin
      m_mem[(addr >> 2) % DEPTH] = wd;
      m_stores = m_stores + 1;
    end
    if (we && is_mmio(addr) && o == 8'h10) m_scr = wd;
    if (popd) m_q.delete(0);
    if (txw && acc) m_q.push_back(wd);
    if (setv) m_ovf = 1'b1;
    else if (clrv) m_ovf = 1'b0;
    m_cycle = m_cycle + 1;
  endtask

  task automatic drive(input logic w, input logic [31:0] a,
                       input logic [31:0] d, input logic r);
    we = w; addr = a; wd = d; rdy = r;
  endtask

  task automatic cyc();
    @(posedge clk);
    m_edge();
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s got %h exp %h", tag, obs, exp);
    end
  endtask

  task automatic rd_chk(input string tag, input logic [31:0] a,
                        input logic [31:0] exp);
    drive(1'b0, a, 32'h0, rdy);
    #1;
    chk(tag, rd, exp);
    chk({tag, "_m"}, rd, m_read(a));
  endtask

  initial begin
    logic [31:0] a;
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 32'(dv), 32'h0);
    chk("rst_data", dd, 32'h0);
    rd_chk("rst_mmio", 32'hFFFF_FF00, 32'h0);
    #1 rst = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 1'b0);
    repeat (5) cyc();
    rd_chk("cycle5", 32'hFFFF_FF00, 32'd5);
    rd_chk("status0", 32'hFFFF_FF0C, 32'h2);
    chk("valid0", 32'(dv), 32'h0);

    drive(1'b1, 32'h40, 32'hDEAD_BEEF, 1'b0);
    #1 chk("ram_old", rd, 32'h0);
    cyc();
    rd_chk("ram_new", 32'h40, 32'hDEAD_BEEF);
    rd_chk("ram_alias", 32'h1040, 32'hDEAD_BEEF);
    rd_chk("stores1", 32'hFFFF_FF04, 32'd1);

    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, 32'hFFFF_FF08, 32'(i), 1'b0);
      cyc();
    end
    rd_chk("status_full", 32'hFFFF_FF0C, 32'h41);
    drive(1'b1, 32'hFFFF_FF08, 32'd5, 1'b0);
    cyc();
    rd_chk("status_ovf", 32'hFFFF_FF0C, 32'h45);
    chk("head_hold", dd, 32'd1);
    chk("head_valid", 32'(dv), 32'h1);
    drive(1'b1, 32'hFFFF_FF0C, 32'h4, 1'b0);
    cyc();
    rd_chk("ovf_clr", 32'hFFFF_FF0C, 32'h41);

    drive(1'b1, 32'hFFFF_FF08, 32'd9, 1'b1);
    cyc();
    rd_chk("full_pp", 32'hFFFF_FF0C, 32'h41);
    chk("head2", dd, 32'd2);
    for (int i = 0; i < 4; i++) begin
      logic [31:0] ex [4] = '{32'd2, 32'd3, 32'd4, 32'd9};
      drive(1'b0, 32'h0, 32'h0, 1'b1);
      #1;
      chk("drain_v", 32'(dv), 32'h1);
      chk("drain_d", dd, ex[i]);
      cyc();
    end
    chk("drained", 32'(dv), 32'h0);

    drive(1'b1, 32'hFFFF_FF10, 32'h1234_5678, 1'b0);
    cyc();
    drive(1'b1, 32'hFFFF_FF00, 32'h0, 1'b0);
    cyc();
    rd_chk("scratch", 32'hFFFF_FF10, 32'h1234_5678);
    rd_chk("cycle_run", 32'hFFFF_FF00, m_cycle);
    rd_chk("off20", 32'hFFFF_FF20, 32'h0);

    drive(1'b1, 32'hFFFF_FF08, 32'd7, 1'b0);
    cyc();
    drive(1'b1, 32'hFFFF_FF08, 32'd8, 1'b0);
    cyc();
    drive(1'b0, 32'h0, 32'h0, 1'b1);
    cyc();
    chk("mid_head", dd, 32'd8);
    #2 rst = 1'b1;
    m_reset();
    #1;
    chk("arst_valid", 32'(dv), 32'h0);
    chk("arst_data", dd, 32'h0);
    rd_chk("arst_cyc", 32'hFFFF_FF00, 32'h0);
    rd_chk("arst_st", 32'hFFFF_FF04, 32'h0);
    rd_chk("arst_scr", 32'hFFFF_FF10, 32'h0);
    rd_chk("arst_ram", 32'h40, 32'hDEAD_BEEF);
    drive(1'b0, 32'h0, 32'h0, 1'b0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    rd_chk("post_cyc", 32'hFFFF_FF00, 32'h0);
    rd_chk("post_st", 32'hFFFF_FF0C, 32'h2);

    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 9) < 4) begin
        a = ($urandom_range(0, 7) << 12)
          | ($urandom_range(0, 31) << 2)
          | $urandom_range(0, 3);
      end else begin
        a = 32'hFFFF_FF00 | 32'(offs[$urandom_range(0, 7)]);
      end
      drive(1'($urandom_range(0, 1)), a, $urandom,
            $urandom_range(0, 2) == 0);
      #1;
      chk("rnd_rd", rd, m_read(a));
      chk("rnd_v", 32'(dv), 32'(m_q.size() != 0));
      if (m_q.size() != 0) chk("rnd_d", dd, m_q[0]);
      cyc();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
